can_crc_check: RTL and testbench
================================

Name: can_crc_check

Overview:
Receive-side CAN 2.0 CRC-15 checker, the counterpart of the transmit-side CRC generator.
- Sits after the bit destuffer and beside the RX frame decoder.
- Accumulates CRC-15 (poly 0x4599) over destuffed bits from SOF through the end of the data field.
- Captures the 15 received CRC bits and checks the CRC delimiter.
- Reports pass, CRC mismatch or delimiter form error once per frame.

Parameters:
CRC_INIT, 15'h0000, LFSR seed loaded at SOF; must equal the seed used by the TX CRC generator.
CRC_POLY, 15'h4599, CAN CRC-15 polynomial without the x^15 term.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
din  in  1  destuffed serial bit
din_valid  in  1  one-cycle strobe, din valid at the bit sample point
sof  in  1  qualifies the current din_valid bit as the SOF bit; starts a new frame
crc_start  in  1  qualifies the current din_valid bit as the first (MSB) bit of the received CRC sequence
busy  out  1  frame in progress (CALC, RECV or DELIM)
done  out  1  one-cycle pulse when the verdict is available
crc_ok  out  1  held high after done if computed CRC == received CRC and delimiter == 1
crc_err  out  1  held high after done on CRC mismatch
delim_err  out  1  held high after done if the delimiter bit == 0
rx_crc  out  15  captured received CRC, MSB first, held until next sof

Behaviour:
- States: IDLE, CALC, RECV, DELIM. Only din_valid cycles advance the state machine; all other cycles hold state.
- Reset: state=IDLE; LFSR=CRC_INIT; rx_crc=0; bit counter=0. busy, done, crc_ok, crc_err and delim_err are all 0.
- LFSR step on a calc bit: nxt = din ^ lfsr[14]; lfsr = {lfsr[13:0],1'b0} ^ (nxt ? CRC_POLY : 0).
- Any state, sof&din_valid:
  - LFSR = step(CRC_INIT, din).
  - Clear rx_crc, counter and all verdict flags.
  - Go to CALC.
  - sof has priority over every other condition, so it restarts a frame even mid-frame.
- IDLE: bits without sof are ignored.
- CALC:
  - din_valid & !crc_start: LFSR steps.
  - din_valid & crc_start: LFSR frozen; din shifts into rx_crc LSB; counter=1; go to RECV.
- RECV:
  - Each din_valid shifts din into rx_crc and increments the counter; crc_start is ignored.
  - The 15th bit (counter reaches 15) moves to DELIM.
- DELIM: the next din_valid samples the delimiter; go to IDLE.
- Verdict: on the cycle after the delimiter sample, done=1 for exactly one cycle. At the same time:
  - crc_err = (lfsr != rx_crc)
  - delim_err = !din_at_delim
  - crc_ok = !crc_err & !delim_err
  - Flags hold until the next sof or rst.
- busy = (state != IDLE), registered.
- Latency: done follows the delimiter din_valid by 1 clk.
- Back-to-back din_valid on consecutive clocks must be supported.
- Reset mid-frame: immediate return to reset values; no done pulse.
- crc_start while in IDLE without sof: ignored.

Optional Feature:
CAN_CRC_ERRCNT_EN
- Defined: adds output err_cnt [7:0].
  - Increments by 1 in the done cycle when crc_err|delim_err.
  - Saturates at 8'hFF; cleared only by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 clks, then rst=0 -> all outputs 0; busy=0; rx_crc=15'h0000.
- Stream with CRC_INIT=0: sof bit din=1, then crc_start with 15 bits of 15'h4599 MSB first, then delimiter 1 -> rx_crc=15'h4599; done pulse 1 clk after delimiter; crc_ok=1; crc_err=0; delim_err=0.
- Same stream with CRC bit 3 flipped (rx 15'h4591) -> done; crc_err=1; crc_ok=0; err_cnt=1 if CAN_CRC_ERRCNT_EN.
- Same as the pass case with delimiter din=0 -> delim_err=1; crc_err=0; crc_ok=0.
- Frame of 19 zero bits (SOF plus 18 zeros), received CRC 15'h0000, delimiter 1, with din_valid every 4th clk -> crc_ok=1; state holds between strobes.
- sof asserted mid-RECV (after 7 CRC bits), then a full passing frame -> no done for the aborted frame; a single done with crc_ok=1 for the second frame.

Source files
------------

// File: rtl/can_crc_check_if.sv
// can_crc_check_if: bit-stream inputs and verdict outputs of the CAN CRC-15 checker; err_cnt present under CAN_CRC_ERRCNT_EN
interface can_crc_check_if;
  logic        din;
  logic        din_valid;
  logic        sof;
  logic        crc_start;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        delim_err;
  logic [14:0] rx_crc;
`ifdef CAN_CRC_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif
  modport master (
    output din, din_valid, sof, crc_start,
`ifdef CAN_CRC_ERRCNT_EN
    input err_cnt,
`endif
    input busy, done, crc_ok, crc_err, delim_err, rx_crc
  );
  modport slave (
    input din, din_valid, sof, crc_start,
`ifdef CAN_CRC_ERRCNT_EN
    output err_cnt,
`endif
    output busy, done, crc_ok, crc_err, delim_err, rx_crc
  );
endinterface

// File: rtl/can_crc_check.sv
// can_crc_check: receive-side CAN CRC-15 checker; CAN_CRC_ERRCNT_EN adds a saturating error counter
module can_crc_check #(
  parameter logic [14:0] CRC_INIT = 15'h0000,
  parameter logic [14:0] CRC_POLY = 15'h4599
) (
  input logic          clk,
  input logic          rst,
  can_crc_check_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, RECV, DELIM} state_t;
  state_t      state;
  logic [14:0] lfsr;
  logic [3:0]  cnt;
  logic        mismatch;
  function automatic logic [14:0] step(input logic [14:0] c, input logic d);
    return {c[13:0], 1'b0} ^ ((d ^ c[14]) ? CRC_POLY : 15'h0000);
  endfunction
  assign mismatch = lfsr != bus.rx_crc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= CRC_INIT;
      cnt           <= 4'd0;
      bus.rx_crc    <= 15'h0000;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.crc_ok    <= 1'b0;
      bus.crc_err   <= 1'b0;
      bus.delim_err <= 1'b0;
`ifdef CAN_CRC_ERRCNT_EN
      bus.err_cnt   <= 8'h00;
`endif
    end else begin
      bus.done <= 1'b0;
      if (bus.din_valid) begin
        if (bus.sof) begin
          state         <= CALC;
          bus.busy      <= 1'b1;
          lfsr          <= step(CRC_INIT, bus.din);
          cnt           <= 4'd0;
          bus.rx_crc    <= 15'h0000;
          bus.crc_ok    <= 1'b0;
          bus.crc_err   <= 1'b0;
          bus.delim_err <= 1'b0;
        end else begin
          case (state)
            CALC: begin
              if (bus.crc_start) begin
                bus.rx_crc <= {bus.rx_crc[13:0], bus.din};
                cnt        <= 4'd1;
                state      <= RECV;
              end else begin
                lfsr <= step(lfsr, bus.din);
              end
            end
            RECV: begin
              bus.rx_crc <= {bus.rx_crc[13:0], bus.din};
              cnt        <= cnt + 4'd1;
              if (cnt == 4'd14) state <= DELIM;
            end
            DELIM: begin
              state         <= IDLE;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.crc_err   <= mismatch;
              bus.delim_err <= !bus.din;
              bus.crc_ok    <= !mismatch && bus.din;
`ifdef CAN_CRC_ERRCNT_EN
              if ((mismatch || !bus.din) && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_can_crc_check.sv
// tb_can_crc_check: directed checks of the CAN CRC-15 checker with hand-computed verdicts
module tb_can_crc_check;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  can_crc_check_if bus ();
  can_crc_check dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done) done_seen++;

  task automatic send_bit(input logic d, input logic s, input logic c, input int gap);
    bus.din = d; bus.sof = s; bus.crc_start = c; bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0; bus.sof = 1'b0; bus.crc_start = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic first, input int nzero, input logic [14:0] crc, input logic dl, input int gap);
    send_bit(first, 1'b1, 1'b0, gap);
    repeat (nzero) send_bit(1'b0, 1'b0, 1'b0, gap);
    for (int i = 14; i >= 0; i--) send_bit(crc[i], 1'b0, i == 14, (i == 0) ? 0 : gap);
    send_bit(dl, 1'b0, 1'b0, 0);
  endtask

  task automatic check_verdict(input string name, input logic [14:0] rx, input logic ok, input logic ce, input logic de);
    total++;
    if ({bus.done, bus.busy, bus.crc_ok, bus.crc_err, bus.delim_err} !== {1'b1, 1'b0, ok, ce, de}) begin
      bad++;
      $display("FAIL %s verdict: done/busy/ok/crc_err/delim_err=%b%b%b%b%b want 10%b%b%b", name,
               bus.done, bus.busy, bus.crc_ok, bus.crc_err, bus.delim_err, ok, ce, de);
    end
    total++;
    if (bus.rx_crc !== rx) begin
      bad++;
      $display("FAIL %s rx_crc: got %h want %h", name, bus.rx_crc, rx);
    end
    @(negedge clk);
    total++;
    if ({bus.done, bus.crc_ok, bus.crc_err, bus.delim_err} !== {1'b0, ok, ce, de}) begin
      bad++;
      $display("FAIL %s hold: done/ok/crc_err/delim_err=%b%b%b%b want 0%b%b%b", name,
               bus.done, bus.crc_ok, bus.crc_err, bus.delim_err, ok, ce, de);
    end
  endtask

  task automatic check_errcnt(input string name, input logic [7:0] want);
`ifdef CAN_CRC_ERRCNT_EN
    total++;
    if (bus.err_cnt !== want) begin
      bad++;
      $display("FAIL %s err_cnt: got %0d want %0d", name, bus.err_cnt, want);
    end
`endif
  endtask

  task automatic test_reset;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.sof = 1'b0; bus.crc_start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.delim_err, bus.rx_crc} !== 20'h0) begin
      bad++;
      $display("FAIL reset outputs: busy/done/ok/ce/de=%b%b%b%b%b rx=%h want all 0",
               bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.delim_err, bus.rx_crc);
    end
    check_errcnt("reset", 8'd0);
    send_bit(1'b1, 1'b0, 1'b1, 2);
    total++;
    if (bus.busy !== 1'b0 || bus.rx_crc !== 15'h0) begin
      bad++;
      $display("FAIL idle_ignore: busy=%b rx=%h want 0 0000", bus.busy, bus.rx_crc);
    end
  endtask

  task automatic test_pass;
    send_frame(1'b1, 0, 15'h4599, 1'b1, 0);
    check_verdict("pass", 15'h4599, 1'b1, 1'b0, 1'b0);
    check_errcnt("pass", 8'd0);
  endtask

  task automatic test_crc_err;
    send_frame(1'b1, 0, 15'h4591, 1'b1, 0);
    check_verdict("crc_err", 15'h4591, 1'b0, 1'b1, 1'b0);
    check_errcnt("crc_err", 8'd1);
  endtask

  task automatic test_delim_err;
    send_frame(1'b1, 0, 15'h4599, 1'b0, 0);
    check_verdict("delim_err", 15'h4599, 1'b0, 1'b0, 1'b1);
    check_errcnt("delim_err", 8'd2);
  endtask

  task automatic test_slow_strobe;
    send_bit(1'b0, 1'b1, 1'b0, 3);
    total++;
    if (bus.busy !== 1'b1 || bus.crc_ok !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL slow_sof: busy=%b ok=%b done=%b want 1 0 0", bus.busy, bus.crc_ok, bus.done);
    end
    repeat (18) send_bit(1'b0, 1'b0, 1'b0, 3);
    for (int i = 14; i >= 0; i--) send_bit(1'b0, 1'b0, i == 14, 3);
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL slow_hold: busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    send_bit(1'b1, 1'b0, 1'b0, 0);
    check_verdict("slow", 15'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_restart;
    done_seen = 0;
    send_bit(1'b1, 1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 1'b1, 0);
    repeat (6) send_bit(1'b1, 1'b0, 1'b0, 0);
    total++;
    if (bus.rx_crc !== 15'h007F) begin
      bad++;
      $display("FAIL restart_partial rx_crc: got %h want 007f", bus.rx_crc);
    end
    send_bit(1'b1, 1'b1, 1'b0, 0);
    total++;
    if (bus.rx_crc !== 15'h0000 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_clear: rx=%h busy=%b want 0000 1", bus.rx_crc, bus.busy);
    end
    for (int i = 14; i >= 0; i--) send_bit(15'h4599 >> i, 1'b0, i == 14, 0);
    send_bit(1'b1, 1'b0, 1'b0, 0);
    check_verdict("restart", 15'h4599, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (done_seen != 1) begin
      bad++;
      $display("FAIL restart_done_count: got %0d want 1", done_seen);
    end
  endtask

  task automatic test_reset_midframe;
    done_seen = 0;
    send_bit(1'b1, 1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 1'b1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) send_bit(1'b1, 1'b0, 1'b0, 0);
    total++;
    if (bus.busy !== 1'b0 || bus.rx_crc !== 15'h0 || done_seen != 0) begin
      bad++;
      $display("FAIL reset_midframe: busy=%b rx=%h dones=%0d want 0 0000 0", bus.busy, bus.rx_crc, done_seen);
    end
    check_errcnt("reset_midframe", 8'd0);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_pass;
    test_crc_err;
    test_delim_err;
    test_slow_strobe;
    test_restart;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
